// File: rtl/disp_arbiter.sv
// Display arbiter: a primary digit source owns the display until a message request takes it over for HOLD_CYCLES.
// Latency: 1 cycle, because every output is registered from the value selected at the preceding rising edge.
// Backpressure: none; msg_req is accepted at every edge where it is high, and msg_ack confirms each acceptance.
// Optional feature: define DISP_ARBITER_BLINK_EN to blink the message decimal points every BLINK_DIV cycles.
module disp_arbiter #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pri_hex,
    input  logic [3:0]  pri_dp,
    input  logic        msg_req,
    input  logic [15:0] msg_hex,
    input  logic [3:0]  msg_dp,
    output logic        msg_ack,
    output logic        msg_busy,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_in
);

    // The timer is wide enough to hold HOLD_CYCLES itself, so the HOLD_CYCLES-1 reload always fits.
    localparam int            TW         = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

    typedef enum logic {
        PRI = 1'b0,
        MSG = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [15:0]   r_hex,   w_hex_nxt;
    logic [3:0]    r_dp,    w_dp_nxt;
    logic          r_ack,   w_ack_nxt;

`ifdef DISP_ARBITER_BLINK_EN
    localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

    // The captured msg_dp is kept apart from dp_in because dp_in is blanked during the off phase.
    logic [3:0]    r_msg_dp,    w_msg_dp_nxt;
    logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic          r_blink_off, w_blink_off_nxt;
`endif

    // Next-state and next-output selection: a request always wins, then an unexpired message holds, else primary.
    always_comb begin
        w_state_nxt     = PRI;
        w_timer_nxt     = '0;
        w_hex_nxt       = pri_hex;
        w_dp_nxt        = pri_dp;
        w_ack_nxt       = 1'b0;
`ifdef DISP_ARBITER_BLINK_EN
        w_msg_dp_nxt    = r_msg_dp;
        w_blink_cnt_nxt = '0;
        w_blink_off_nxt = 1'b0;
`endif
        if (msg_req) begin
            // The request is accepted in either state, and also when the timer has just expired.
            w_state_nxt     = MSG;
            w_timer_nxt     = TIMER_LOAD;
            w_hex_nxt       = msg_hex;
            w_dp_nxt        = msg_dp;
            w_ack_nxt       = 1'b1;
`ifdef DISP_ARBITER_BLINK_EN
            w_msg_dp_nxt    = msg_dp;
            w_blink_cnt_nxt = '0;
            w_blink_off_nxt = 1'b0;
`endif
        end else if (r_state == MSG && r_timer != '0) begin
            // The message keeps the display and pri_* is ignored. The timer stops at 0 and never wraps.
            w_state_nxt = MSG;
            w_timer_nxt = r_timer - TW'(1);
            w_hex_nxt   = r_hex;
`ifdef DISP_ARBITER_BLINK_EN
            if (r_blink_cnt == BLINK_TOP) begin
                w_blink_cnt_nxt = '0;
                w_blink_off_nxt = ~r_blink_off;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BW'(1);
                w_blink_off_nxt = r_blink_off;
            end
            w_dp_nxt = w_blink_off_nxt ? 4'b0000 : r_msg_dp;
`else
            w_dp_nxt = r_dp;
`endif
        end
    end

    // State, timer and the registered display outputs; reset abandons any message without an ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= PRI;
            r_timer <= '0;
            r_hex   <= '0;
            r_dp    <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_hex   <= w_hex_nxt;
            r_dp    <= w_dp_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

`ifdef DISP_ARBITER_BLINK_EN
    // Blink phase and the captured message decimal points.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_msg_dp    <= '0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else begin
            r_msg_dp    <= w_msg_dp_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_off <= w_blink_off_nxt;
        end
    end
`endif

    assign msg_ack  = r_ack;
    assign msg_busy = (r_state == MSG);
    assign hex3     = r_hex[15:12];
    assign hex2     = r_hex[11:8];
    assign hex1     = r_hex[7:4];
    assign hex0     = r_hex[3:0];
    assign dp_in    = r_dp;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with HOLD_CYCLES=8 and BLINK_DIV=2.
// Outputs are sampled 1 ns after each rising edge, and inputs change at that same point.
// The expected dp_in during a message follows the blink macro when the bench is built with it.
module tb_disp_arbiter;

    localparam int HOLD = 8;
    localparam int BDIV = 2;

    logic        clk;
    logic        reset_n;
    logic [15:0] pri_hex;
    logic [3:0]  pri_dp;
    logic        msg_req;
    logic [15:0] msg_hex;
    logic [3:0]  msg_dp;
    logic        msg_ack;
    logic        msg_busy;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_in;

    int n_cmp;
    int n_err;
    int busy_acc;

    disp_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_DIV(BDIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pri_hex  (pri_hex),
        .pri_dp   (pri_dp),
        .msg_req  (msg_req),
        .msg_hex  (msg_hex),
        .msg_dp   (msg_dp),
        .msg_ack  (msg_ack),
        .msg_busy (msg_busy),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .dp_in    (dp_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (msg_busy === 1'b1) busy_acc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ehex, input logic [3:0] edp,
                           input logic ebusy, input logic eack);
        chk({tag, ".hex"},  {16'h0, hex3, hex2, hex1, hex0}, {16'h0, ehex});
        chk({tag, ".dp"},   {28'h0, dp_in}, {28'h0, edp});
        chk({tag, ".busy"}, {31'h0, msg_busy}, {31'h0, ebusy});
        chk({tag, ".ack"},  {31'h0, msg_ack}, {31'h0, eack});
    endtask

    // Expected message dp for the c-th displayed cycle (c=0 is the cycle after acceptance).
    function automatic logic [3:0] mdp(input logic [3:0] dp, input int c);
`ifdef DISP_ARBITER_BLINK_EN
        return (((c / BDIV) % 2) == 0) ? dp : 4'b0000;
`else
        return (c >= 0) ? dp : 4'b0000;
`endif
    endfunction

    // Ticks n times and checks a held (non-acked) message from display cycle first_c onward.
    task automatic run_msg(input string tag, input int first_c, input int n,
                           input logic [15:0] hx, input logic [3:0] dp);
        for (int c = first_c; c < first_c + n; c++) begin
            tick();
            chk_out(tag, hx, mdp(dp, c), 1'b1, 1'b0);
        end
    endtask

    task automatic accept(input logic [15:0] hx, input logic [3:0] dp);
        msg_req = 1'b1;
        msg_hex = hx;
        msg_dp  = dp;
        tick();
        msg_req = 1'b0;
        msg_hex = 16'hFFFF;
        msg_dp  = 4'b1111;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        busy_acc = 0;
        reset_n  = 1'b1;
        pri_hex  = 16'h1234;
        pri_dp   = 4'b0000;
        msg_req  = 1'b0;
        msg_hex  = 16'h0000;
        msg_dp   = 4'b0000;

        // Reset asserts asynchronously, before any clock edge.
        #1 reset_n = 1'b0;
        #2;
        chk_out("rst_async", 16'h0000, 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("rst_held", 16'h0000, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b1;

        // First edge after release loads the primary digits.
        tick();
        chk_out("pri_first", 16'h1234, 4'b0000, 1'b0, 1'b0);
        pri_dp = 4'b0010;
        tick();
        chk_out("pri_dp", 16'h1234, 4'b0010, 1'b0, 1'b0);
        pri_dp = 4'b0000;
        tick();

        // Single-cycle request: 8 message cycles, with primary changes ignored meanwhile.
        accept(16'hABCD, 4'b0101);
        chk_out("m1_accept", 16'hABCD, mdp(4'b0101, 0), 1'b1, 1'b1);
        pri_hex = 16'h5678;
        pri_dp  = 4'b1000;
        run_msg("m1_hold", 1, HOLD - 1, 16'hABCD, 4'b0101);
        tick();
        chk_out("m1_return", 16'h5678, 4'b1000, 1'b0, 1'b0);
        tick();
        chk_out("m1_pri2", 16'h5678, 4'b1000, 1'b0, 1'b0);

        // A second request in the 5th message cycle restarts the hold: 13 busy cycles in total.
        busy_acc = 0;
        accept(16'hABCD, 4'b0101);
        chk_out("m2_accept", 16'hABCD, mdp(4'b0101, 0), 1'b1, 1'b1);
        run_msg("m2_first", 1, 4, 16'hABCD, 4'b0101);
        accept(16'h00EE, 4'b1010);
        chk_out("m2_reacc", 16'h00EE, mdp(4'b1010, 0), 1'b1, 1'b1);
        run_msg("m2_second", 1, HOLD - 1, 16'h00EE, 4'b1010);
        tick();
        chk_out("m2_return", 16'h5678, 4'b1000, 1'b0, 1'b0);
        chk("m2_busy_total", busy_acc, 13);

        // A request on the edge where the timer is 0 leaves no primary cycle in between.
        accept(16'h1111, 4'b0011);
        chk_out("m3_accept", 16'h1111, mdp(4'b0011, 0), 1'b1, 1'b1);
        run_msg("m3_hold", 1, HOLD - 1, 16'h1111, 4'b0011);
        accept(16'h2222, 4'b1100);
        chk_out("m3_timer0", 16'h2222, mdp(4'b1100, 0), 1'b1, 1'b1);
        run_msg("m3_hold2", 1, HOLD - 1, 16'h2222, 4'b1100);
        tick();
        chk_out("m3_return", 16'h5678, 4'b1000, 1'b0, 1'b0);

        // A request held high is re-acked every edge, then holds 8 cycles after its last acceptance.
        msg_req = 1'b1;
        msg_hex = 16'h3333;
        msg_dp  = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("m4_held", 16'h3333, mdp(4'b0001, 0), 1'b1, 1'b1);
        end
        msg_req = 1'b0;
        run_msg("m4_hold", 1, HOLD - 1, 16'h3333, 4'b0001);
        tick();
        chk_out("m4_return", 16'h5678, 4'b1000, 1'b0, 1'b0);

        // Reset in the 3rd message cycle abandons the message with no ack.
        pri_hex = 16'h1234;
        pri_dp  = 4'b0000;
        accept(16'h4444, 4'b0110);
        chk_out("m5_accept", 16'h4444, mdp(4'b0110, 0), 1'b1, 1'b1);
        run_msg("m5_hold", 1, 2, 16'h4444, 4'b0110);
        reset_n = 1'b0;
        #1;
        chk_out("m5_rst_async", 16'h0000, 4'b0000, 1'b0, 1'b0);
        tick();
        chk_out("m5_rst_held", 16'h0000, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("m5_after", 16'h1234, 4'b0000, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
